sign_quadrant_monitor: RTL
==========================

# sign_quadrant_monitor

Parametrised multi-channel streaming sign-condition detector for the `whatever` verification package family. It accepts beats of CHANNELS signed (x, y) pairs over a valid/ready handshake and evaluates a run-time-selectable quadrant condition per channel, a generalisation of the single-pair `x < 0 && y > 0` check. It keeps per-channel hit counters and runs a bounded capture window of FIN_BEATS accepted beats. At the end of the window it drains the output register and raises `done`.

## Interface
- DATA_W, 32, signed width of each x and y operand (≥2)
- CHANNELS, 4, number of parallel pairs per beat (≥1)
- CNT_W, 16, width of each per-channel hit counter (≥1)
- FIN_BEATS, 100, accepted beats per capture window (≥1)

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begins a window from IDLE or DONE; ignored in RUN and DRAIN
- mode  in  2  condition select, sampled with each accepted beat
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_x  in  CHANNELS*DATA_W  channel c at bits [c*DATA_W +: DATA_W], two's complement
- in_y  in  CHANNELS*DATA_W  same packing as in_x
- out_valid  out  1  result beat valid
- out_ready  in  1  result consumer ready
- out_hit  out  CHANNELS  per-channel condition result of the held beat
- hit_cnt  out  CHANNELS*CNT_W  per-channel hit counters, same packing
- cnt_sat  out  CHANNELS  per-channel counter-saturated flags (see Configuration)
- done  out  1  window complete

## Operation
- Operand sign classes are NEG (<0), ZERO, and POS (>0). ZERO never produces a hit in any mode.
- Modes:
  - 0: x NEG && y POS (legacy)
  - 1: x POS && y NEG
  - 2: same strict sign, both NEG or both POS
  - 3: opposite strict sign, mode 0 or mode 1
- FSM states:
  - IDLE → RUN on start. Counters, cnt_sat and beat counter clear in the same edge.
  - RUN → DRAIN on the edge that accepts beat number FIN_BEATS.
  - DRAIN → DONE when out_valid is 0, or when out_valid && out_ready in that cycle.
  - DONE → RUN on start, with the same clears as from IDLE.
- in_ready = (state == RUN) && (!out_valid || out_ready). It is combinational from the state and output register only, with no dependency on in_valid.
- On acceptance:
  - out_hit is loaded and out_valid is set.
  - For each channel, hit_cnt[c] increments when its hit is 1.
  - The beat counter increments. Its width is $clog2(FIN_BEATS+1).
- out_valid clears on out_valid && out_ready with no simultaneous acceptance. With a simultaneous acceptance the output register reloads and out_valid stays 1.
- out_hit is held stable while out_valid && !out_ready.
- done = (state == DONE), registered.
- start and in_valid in the same cycle from IDLE: start is taken and in_valid is not accepted, because in_ready is 0 in IDLE.
- rst at any point, including mid-window, aborts immediately. All state is cleared and no partial result is delivered.

## Timing
- Reset values:
  - state IDLE
  - in_ready 0
  - out_valid 0
  - out_hit 0
  - hit_cnt all 0
  - cnt_sat 0
  - done 0
- Latency: a beat accepted at edge N is presented on out_hit/out_valid and reflected in hit_cnt after edge N. That is one cycle.
- Sustained throughput is 1 beat/cycle while out_ready = 1.
- The first accept is possible in the cycle after start is sampled.
- done rises on the cycle after the DRAIN exit edge at the earliest. With out_ready held at 1, done is high 2 cycles after the final acceptance edge.

## Configuration
- Macro: SIGN_QUADRANT_MONITOR_SAT_EN.
- Defined:
  - Each hit_cnt saturates at 2^CNT_W−1.
  - cnt_sat[c] sets on the increment that reaches the maximum and stays set until start or rst.
- Undefined:
  - Counters wrap modulo 2^CNT_W.
  - cnt_sat is tied to 0.
- The port list is identical in both builds.

## Test plan
- Mode 0 legacy check (CHANNELS=4, DATA_W=8):
  - Stimulus: x = {−1, 5, 0, −128}, y = {1, 1, 3, 127}.
  - Required: out_hit = 4'b1001 one cycle after accept, hit_cnt = {1,0,0,1}.
- Zero and mode sweep:
  - Stimulus: x = 0 or y = 0 under modes 0–3.
  - Required: out_hit = 0 for every mode.
  - Stimulus: x = 3, y = 4 in mode 2.
  - Required: hit.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles while in_valid = 1.
  - Required: exactly one beat accepted, in_ready = 0 afterwards, out_hit stable.
  - On release, one beat/cycle resumes and no beat is lost or duplicated.
- Window end (FIN_BEATS=3):
  - Stimulus: stream 5 beats with out_ready = 1.
  - Required: only 3 accepted, in_ready drops after the 3rd, done = 1 two cycles after the 3rd accept.
  - Then start: hit_cnt and done clear and RUN resumes.
- Counter limit (CNT_W=2):
  - Stimulus: 5 hits on channel 0.
  - Required with SIGN_QUADRANT_MONITOR_SAT_EN: hit_cnt[0] = 3 and cnt_sat[0] = 1.
  - Required without the macro: hit_cnt[0] = 1 and cnt_sat[0] = 0.
- Reset mid-window:
  - Stimulus: assert rst asynchronously between clock edges during RUN with out_valid = 1.
  - Required: all outputs reach their reset values before the next edge, and state is IDLE.

Source files
------------

// File: rtl/sign_quadrant_monitor.sv
// Streaming per-channel quadrant detector with hit counters and a bounded capture window.
// Build option SIGN_QUADRANT_MONITOR_SAT_EN: counters saturate and flag cnt_sat instead of wrapping.
module sign_quadrant_monitor #(
  parameter int DATA_W    = 32,
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = 16,
  parameter int FIN_BEATS = 100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] in_x,
  input  logic [CHANNELS*DATA_W-1:0] in_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHANNELS-1:0]        out_hit,
  output logic [CHANNELS*CNT_W-1:0]  hit_cnt,
  output logic [CHANNELS-1:0]        cnt_sat,
  output logic                       done
);

  localparam int BEAT_W = $clog2(FIN_BEATS + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FIN_BEATS - 1);
`ifdef SIGN_QUADRANT_MONITOR_SAT_EN
  localparam logic [CNT_W-1:0] CNT_PEN = ~CNT_W'(1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Handshakes: a beat transfers on an edge where valid && ready are both high;
  // in_ready never looks at in_valid, and out_hit holds while out_valid && !out_ready.
  state_t                      state_q, state_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic                        out_valid_q, out_valid_d;
  logic [CHANNELS-1:0]         out_hit_q, out_hit_d;
  logic [CHANNELS*CNT_W-1:0]   cnt_q, cnt_d;
  logic [CHANNELS-1:0]         sat_q, sat_d;
  logic                        done_q, done_d;

  logic [CHANNELS-1:0] x_neg, x_pos, y_neg, y_pos;
  logic [CHANNELS-1:0] hit;
  logic                accept;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_sign
    assign x_neg[c] = in_x[c*DATA_W + DATA_W - 1];
    assign x_pos[c] = !x_neg[c] && (|in_x[c*DATA_W +: DATA_W]);
    assign y_neg[c] = in_y[c*DATA_W + DATA_W - 1];
    assign y_pos[c] = !y_neg[c] && (|in_y[c*DATA_W +: DATA_W]);
  end

  always_comb begin
    hit = '0;
    case (mode)
      2'd0:    hit = x_neg & y_pos;
      2'd1:    hit = x_pos & y_neg;
      2'd2:    hit = (x_neg & y_neg) | (x_pos & y_pos);
      default: hit = (x_neg & y_pos) | (x_pos & y_neg);
    endcase
  end

  assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    out_hit_d   = out_hit_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    done_d      = (state_q == S_DONE);

    if (accept) begin
      out_valid_d = 1'b1;
      out_hit_d   = hit;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          beat_d  = '0;
          cnt_d   = '0;
          sat_d   = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          beat_d = beat_q + BEAT_W'(1);
          for (int c = 0; c < CHANNELS; c++) begin
            if (hit[c]) begin
`ifdef SIGN_QUADRANT_MONITOR_SAT_EN
              if (cnt_q[c*CNT_W +: CNT_W] != '1) begin
                cnt_d[c*CNT_W +: CNT_W] = cnt_q[c*CNT_W +: CNT_W] + CNT_W'(1);
                if (cnt_q[c*CNT_W +: CNT_W] == CNT_PEN) sat_d[c] = 1'b1;
              end
`else
              cnt_d[c*CNT_W +: CNT_W] = cnt_q[c*CNT_W +: CNT_W] + CNT_W'(1);
`endif
            end
          end
          if (beat_q == LAST_BEAT) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!out_valid_q || out_ready) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_hit_q   <= '0;
      cnt_q       <= '0;
      sat_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      out_hit_q   <= out_hit_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_hit   = out_hit_q;
  assign hit_cnt   = cnt_q;
  assign cnt_sat   = sat_q;
  assign done      = done_q;

endmodule
